hazard_scoreboard_fwd: RTL and testbench
========================================

Name: hazard_scoreboard_fwd

Overview:
- Parametrised successor to the pipeline hazard/forward unit.
- Supports an arbitrary number of register read ports and forwarding stages.
- Adds a per-register pending-write scoreboard for long-latency ops (multi-cycle mul/div, non-blocking loads) that complete out of band on a completion bus.
- Sits beside the pipeline control path; produces forward selects per read port, one combined stall, and sequential status (pending vector, stall statistics, error flag).

Parameters:
- NUM_RD_PORTS, 2, number of register read ports checked each cycle.
- NUM_FWD_STAGES, 3, forwarding stages; index 0 is nearest (EX), ascending toward WB.
- REG_AW, 5, register address width.
- NUM_REGS, 32, register count; register 0 is hardwired zero.
- STALL_CNT_W, 16, width of the saturating stall-cycle counter.
- SEL_W, derived as clog2(NUM_FWD_STAGES+2), forward-select width.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- rd_addr  in  NUM_RD_PORTS*REG_AW  read register per port.
- rd_want  in  NUM_RD_PORTS  port wants data: forward if available, never stall.
- rd_need  in  NUM_RD_PORTS  port needs data: stall if not yet available.
- stg_dst  in  NUM_FWD_STAGES*REG_AW  destination register per stage.
- stg_regwrite  in  NUM_FWD_STAGES  stage will write stg_dst.
- stg_data_ready  in  NUM_FWD_STAGES  stage result is forwardable this cycle (0 for memory access in progress).
- issue_valid  in  1  long-latency op requests issue.
- issue_dst  in  REG_AW  its destination register.
- cmpl_valid  in  1  long-latency result on the completion bus this cycle.
- cmpl_dst  in  REG_AW  completing register.
- ext_stall  in  1  downstream/memory stall, OR'd into stall.
- fwd_sel  out  NUM_RD_PORTS*SEL_W  per-port select: 0 = regfile, k+1 = stage k, NUM_FWD_STAGES+1 = completion bus.
- stall  out  1  combined stall.
- issue_accept  out  1  issue taken this cycle.
- pending  out  NUM_REGS  registered scoreboard bits.
- busy  out  1  OR of pending.
- stall_count  out  STALL_CNT_W  saturating count of cycles with stall=1.
- err_sticky  out  1  completion seen for a non-pending register.

Behaviour:
- Reset (asynchronous): pending=0, stall_count=0, err_sticky=0. Combinational outputs follow their inputs during reset; issue_accept is forced 0.
- Per port, active = rd_want|rd_need, and rd_addr != 0. Inactive port: fwd_sel=0, no stall contribution.
- Stage match k: stg_regwrite[k] & stg_dst[k]==rd_addr & stg_dst[k]!=0. Lowest-index match wins; younger stages shadow older ones.
- Winning stage ready: fwd_sel=k+1.
- Winning stage not ready: fwd_sel=0; stall if rd_need.
- No stage match, pending[rd_addr], and cmpl_valid with cmpl_dst==rd_addr: fwd_sel=NUM_FWD_STAGES+1, no stall.
- No stage match, pending, no completion for that register: fwd_sel=0; stall if rd_need.
- Otherwise fwd_sel=0.
- WAW stall: issue_valid & pending[issue_dst] & issue_dst!=0 & ~(cmpl_valid & cmpl_dst==issue_dst).
- stall = OR(port stalls) | waw_stall | ext_stall.
- issue_accept = issue_valid & ~stall & ~reset.
- Scoreboard update at clock edge:
  - Set pending[issue_dst] on issue_accept with issue_dst!=0.
  - Clear pending[cmpl_dst] on cmpl_valid.
  - Same register set and cleared in one cycle: set wins.
  - Issue to register 0: accepted, never marked pending.
- cmpl_valid with pending[cmpl_dst]==0 and cmpl_dst!=0: err_sticky<=1, held until reset; pending unchanged.
- stall_count increments each cycle stall=1; saturates at all-ones.
- Latency: fwd_sel, stall and issue_accept are combinational from inputs and current pending (0 cycles). pending and busy reflect updates 1 cycle later.

Decomposition:
- Package hazard_pkg holds:
  - SEL_REGFILE = 0.
  - function sel_stage(k) = k+1.
  - function sel_cmpl(S) = S+1.
  - clog2 helper.
- One sub-module, hazard_port_select: single-port priority match and select. Instantiated NUM_RD_PORTS times in a generate loop; the top keeps the scoreboard, WAW logic, counters and stall OR.

Test Plan:
- Stage-0 ALU result: port0 need, rd_addr=8, stg_dst[0]=8, regwrite=1, ready=1 -> fwd_sel0=1, stall=0.
- Load-use: stg_dst[1]=9, ready=0, port1 need rd_addr=9 -> stall=1, fwd_sel1=0. Next cycle ready=1 -> fwd_sel1=2, stall=0. Want-only port in the same setup -> fwd_sel=0, stall=0.
- Long op: issue_dst=12 accepted -> pending[12]=1 next cycle. Port0 need 12 -> stall until cmpl_valid,cmpl_dst=12, which gives fwd_sel0=4 (S=3), stall=0; pending[12]=0 the following cycle.
- WAW and same-cycle: with pending[12], issue_dst=12 without completion -> stall=1, issue_accept=0. With cmpl_dst=12 in the same cycle -> issue_accept=1, pending[12] stays 1.
- Errors and register 0: cmpl_dst=5 while not pending -> err_sticky=1 until reset. issue_dst=0 -> pending stays 0, busy=0. Reset asserted mid-pending -> pending=0 immediately, stall_count=0.
- Saturation: STALL_CNT_W=4, ext_stall held 20 cycles -> stall_count=15.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared select encodings, source classification and helpers for the hazard/forward unit.
package hazard_pkg;

  localparam int SEL_REGFILE = 0;

  // Where a read port's operand comes from; the *_WAIT kinds are the stall cases.
  typedef enum logic [2:0] {
    SRC_REGFILE,
    SRC_STAGE,
    SRC_STAGE_WAIT,
    SRC_CMPL,
    SRC_PEND_WAIT
  } src_e;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction

  function automatic int sel_stage(input int k);
    return k + 1;
  endfunction

  function automatic int sel_cmpl(input int num_stages);
    return num_stages + 1;
  endfunction

endpackage

// File: rtl/hazard_port_select.sv
// Single read port: priority match against the forwarding stages, then scoreboard fallback.
module hazard_port_select
  import hazard_pkg::*;
#(
  parameter int NUM_FWD_STAGES = 3,
  parameter int REG_AW         = 5,
  parameter int SEL_W          = 3
) (
  input  logic [REG_AW-1:0]                rd_addr,
  input  logic                             rd_want,
  input  logic                             rd_need,
  input  logic [NUM_FWD_STAGES*REG_AW-1:0] stg_dst,
  input  logic [NUM_FWD_STAGES-1:0]        stg_regwrite,
  input  logic [NUM_FWD_STAGES-1:0]        stg_data_ready,
  input  logic                             rd_pending,
  input  logic                             cmpl_valid,
  input  logic [REG_AW-1:0]                cmpl_dst,
  output logic [SEL_W-1:0]                 fwd_sel,
  output logic                             stall
);

  logic             hit;
  logic             hit_ready;
  logic [SEL_W-1:0] hit_sel;
  src_e             src;

  // Walk from oldest to youngest so the youngest (lowest index) match is left standing.
  always_comb begin
    hit       = 1'b0;
    hit_ready = 1'b0;
    hit_sel   = SEL_W'(SEL_REGFILE);
    for (int k = NUM_FWD_STAGES - 1; k >= 0; k--) begin
      if (stg_regwrite[k] && stg_dst[k*REG_AW +: REG_AW] == rd_addr &&
          stg_dst[k*REG_AW +: REG_AW] != '0) begin
        hit       = 1'b1;
        hit_ready = stg_data_ready[k];
        hit_sel   = SEL_W'(sel_stage(k));
      end
    end
  end

  always_comb begin
    src = SRC_REGFILE;
    if ((rd_want || rd_need) && rd_addr != '0) begin
      if (hit) begin
        src = hit_ready ? SRC_STAGE : SRC_STAGE_WAIT;
      end else if (rd_pending) begin
        src = (cmpl_valid && cmpl_dst == rd_addr) ? SRC_CMPL : SRC_PEND_WAIT;
      end
    end
  end

  always_comb begin
    fwd_sel = SEL_W'(SEL_REGFILE);
    stall   = 1'b0;
    case (src)
      SRC_STAGE:                    fwd_sel = hit_sel;
      SRC_CMPL:                     fwd_sel = SEL_W'(sel_cmpl(NUM_FWD_STAGES));
      SRC_STAGE_WAIT, SRC_PEND_WAIT: stall  = rd_need;
      default:                      fwd_sel = SEL_W'(SEL_REGFILE);
    endcase
  end

endmodule

// File: rtl/hazard_scoreboard_fwd.sv
// Hazard/forward unit with a pending-write scoreboard for long-latency ops.
module hazard_scoreboard_fwd
  import hazard_pkg::*;
#(
  parameter  int NUM_RD_PORTS   = 2,
  parameter  int NUM_FWD_STAGES = 3,
  parameter  int REG_AW         = 5,
  parameter  int NUM_REGS       = 32,
  parameter  int STALL_CNT_W    = 16,
  localparam int SEL_W          = clog2(NUM_FWD_STAGES + 2)
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic [NUM_RD_PORTS*REG_AW-1:0]   rd_addr,
  input  logic [NUM_RD_PORTS-1:0]          rd_want,
  input  logic [NUM_RD_PORTS-1:0]          rd_need,
  input  logic [NUM_FWD_STAGES*REG_AW-1:0] stg_dst,
  input  logic [NUM_FWD_STAGES-1:0]        stg_regwrite,
  input  logic [NUM_FWD_STAGES-1:0]        stg_data_ready,
  input  logic                             issue_valid,
  input  logic [REG_AW-1:0]                issue_dst,
  input  logic                             cmpl_valid,
  input  logic [REG_AW-1:0]                cmpl_dst,
  input  logic                             ext_stall,
  output logic [NUM_RD_PORTS*SEL_W-1:0]    fwd_sel,
  output logic                             stall,
  output logic                             issue_accept,
  output logic [NUM_REGS-1:0]              pending,
  output logic                             busy,
  output logic [STALL_CNT_W-1:0]           stall_count,
  output logic                             err_sticky
);

  logic [NUM_RD_PORTS-1:0] port_stall;
  logic                    waw_stall;
  logic                    cmpl_err;
  logic [NUM_REGS-1:0]     pending_next;

  for (genvar p = 0; p < NUM_RD_PORTS; p++) begin : g_port
    hazard_port_select #(
      .NUM_FWD_STAGES(NUM_FWD_STAGES),
      .REG_AW        (REG_AW),
      .SEL_W         (SEL_W)
    ) u_sel (
      .rd_addr       (rd_addr[p*REG_AW +: REG_AW]),
      .rd_want       (rd_want[p]),
      .rd_need       (rd_need[p]),
      .stg_dst       (stg_dst),
      .stg_regwrite  (stg_regwrite),
      .stg_data_ready(stg_data_ready),
      .rd_pending    (pending[rd_addr[p*REG_AW +: REG_AW]]),
      .cmpl_valid    (cmpl_valid),
      .cmpl_dst      (cmpl_dst),
      .fwd_sel       (fwd_sel[p*SEL_W +: SEL_W]),
      .stall         (port_stall[p])
    );
  end

  // A same-cycle completion retires the old write, so a re-issue to that register is safe.
  always_comb begin
    waw_stall    = issue_valid && issue_dst != '0 && pending[issue_dst] &&
                   !(cmpl_valid && cmpl_dst == issue_dst);
    stall        = (|port_stall) || waw_stall || ext_stall;
    issue_accept = issue_valid && !stall && !reset;
    busy         = |pending;
    cmpl_err     = cmpl_valid && cmpl_dst != '0 && !pending[cmpl_dst];
  end

  // Clear before set so a same-cycle issue to the completing register keeps it pending.
  always_comb begin
    pending_next = pending;
    if (cmpl_valid) pending_next[cmpl_dst] = 1'b0;
    if (issue_accept && issue_dst != '0) pending_next[issue_dst] = 1'b1;
    pending_next[0] = 1'b0;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pending     <= '0;
      stall_count <= '0;
      err_sticky  <= 1'b0;
    end else begin
      pending <= pending_next;
      if (cmpl_err) err_sticky <= 1'b1;
      if (stall && stall_count != '1) stall_count <= stall_count + STALL_CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard_fwd.sv
// Directed plus randomized bench for hazard_scoreboard_fwd against a per-register reference model.
module tb_hazard_scoreboard_fwd;

  localparam int NP  = 2;
  localparam int NS  = 3;
  localparam int AW  = 5;
  localparam int NR  = 32;
  localparam int CW  = 4;
  localparam int SW  = 3;
  localparam int SAT = 15;

  logic             clock = 1'b0;
  logic             reset = 1'b0;
  logic [NP*AW-1:0] rd_addr;
  logic [NP-1:0]    rd_want;
  logic [NP-1:0]    rd_need;
  logic [NS*AW-1:0] stg_dst;
  logic [NS-1:0]    stg_regwrite;
  logic [NS-1:0]    stg_data_ready;
  logic             issue_valid;
  logic [AW-1:0]    issue_dst;
  logic             cmpl_valid;
  logic [AW-1:0]    cmpl_dst;
  logic             ext_stall;
  logic [NP*SW-1:0] fwd_sel;
  logic             stall;
  logic             issue_accept;
  logic [NR-1:0]    pending;
  logic             busy;
  logic [CW-1:0]    stall_count;
  logic             err_sticky;

  hazard_scoreboard_fwd #(
    .NUM_RD_PORTS  (NP),
    .NUM_FWD_STAGES(NS),
    .REG_AW        (AW),
    .NUM_REGS      (NR),
    .STALL_CNT_W   (CW)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .rd_addr       (rd_addr),
    .rd_want       (rd_want),
    .rd_need       (rd_need),
    .stg_dst       (stg_dst),
    .stg_regwrite  (stg_regwrite),
    .stg_data_ready(stg_data_ready),
    .issue_valid   (issue_valid),
    .issue_dst     (issue_dst),
    .cmpl_valid    (cmpl_valid),
    .cmpl_dst      (cmpl_dst),
    .ext_stall     (ext_stall),
    .fwd_sel       (fwd_sel),
    .stall         (stall),
    .issue_accept  (issue_accept),
    .pending       (pending),
    .busy          (busy),
    .stall_count   (stall_count),
    .err_sticky    (err_sticky)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  bit pend_m[NR];
  bit err_m;
  int cnt_m;
  bit exp_stall;
  bit exp_acc;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NR-1:0] pend_vec();
    logic [NR-1:0] v;
    for (int i = 0; i < NR; i++) v[i] = pend_m[i];
    return v;
  endfunction

  // Operand source for one port, straight from the rule list: youngest matching stage, else scoreboard.
  function automatic void model_port(input int p, output int sel, output bit st);
    int a;
    a   = int'(rd_addr[p*AW +: AW]);
    sel = 0;
    st  = 1'b0;
    if (!(rd_want[p] || rd_need[p]) || a == 0) return;
    for (int k = 0; k < NS; k++) begin
      if (stg_regwrite[k] && int'(stg_dst[k*AW +: AW]) == a) begin
        if (stg_data_ready[k]) sel = k + 1;
        else st = rd_need[p];
        return;
      end
    end
    if (pend_m[a]) begin
      if (cmpl_valid && int'(cmpl_dst) == a) sel = NS + 1;
      else st = rd_need[p];
    end
  endfunction

  task automatic clear_inputs();
    rd_addr = '0; rd_want = '0; rd_need = '0;
    stg_dst = '0; stg_regwrite = '0; stg_data_ready = '0;
    issue_valid = 1'b0; issue_dst = '0;
    cmpl_valid = 1'b0; cmpl_dst = '0; ext_stall = 1'b0;
  endtask

  task automatic set_port(input int p, input int addr, input bit want, input bit need);
    rd_addr[p*AW +: AW] = AW'(addr);
    rd_want[p] = want;
    rd_need[p] = need;
  endtask

  task automatic set_stage(input int k, input int dst, input bit rw, input bit rdy);
    stg_dst[k*AW +: AW] = AW'(dst);
    stg_regwrite[k]     = rw;
    stg_data_ready[k]   = rdy;
  endtask

  task automatic applyStimulus();
    for (int p = 0; p < NP; p++) set_port(p, $urandom_range(0, 7), 1'($urandom), 1'($urandom));
    for (int k = 0; k < NS; k++) set_stage(k, $urandom_range(0, 7), 1'($urandom), 1'($urandom));
    issue_valid = ($urandom % 3) == 0;
    issue_dst   = AW'($urandom_range(0, 7));
    cmpl_valid  = ($urandom % 3) == 0;
    cmpl_dst    = AW'($urandom_range(0, 7));
    ext_stall   = ($urandom % 8) == 0;
  endtask

  task automatic checkOutput();
    logic [NP*SW-1:0] exp_sel;
    int sel;
    bit st;
    bit any_st;
    bit waw;
    #1;
    exp_sel = '0;
    any_st  = 1'b0;
    for (int p = 0; p < NP; p++) begin
      model_port(p, sel, st);
      exp_sel[p*SW +: SW] = sel[SW-1:0];
      any_st = any_st | st;
    end
    waw = issue_valid && issue_dst != 0 && pend_m[issue_dst] &&
          !(cmpl_valid && cmpl_dst == issue_dst);
    exp_stall = any_st || waw || ext_stall;
    exp_acc   = issue_valid && !exp_stall;
    check("fwd_sel", 64'(fwd_sel), 64'(exp_sel));
    check("stall", 64'(stall), 64'(exp_stall));
    check("issue_accept", 64'(issue_accept), 64'(exp_acc));
    check("pending", 64'(pending), 64'(pend_vec()));
    check("busy", 64'(busy), 64'(pend_vec() != 0));
    check("stall_count", 64'(stall_count), 64'(cnt_m));
    check("err_sticky", 64'(err_sticky), 64'(err_m));
  endtask

  task automatic tick();
    @(posedge clock);
    if (exp_stall && cnt_m < SAT) cnt_m++;
    if (cmpl_valid && cmpl_dst != 0 && !pend_m[cmpl_dst]) err_m = 1'b1;
    if (cmpl_valid) pend_m[cmpl_dst] = 1'b0;
    if (exp_acc && issue_dst != 0) pend_m[issue_dst] = 1'b1;
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    for (int i = 0; i < NR; i++) pend_m[i] = 1'b0;
    err_m = 1'b0;
    cnt_m = 0;
    issue_valid = 1'b1;
    #1;
    check("rst_pending", 64'(pending), 64'(0));
    check("rst_stall_count", 64'(stall_count), 64'(0));
    check("rst_err", 64'(err_sticky), 64'(0));
    check("rst_issue_accept", 64'(issue_accept), 64'(0));
    @(posedge clock);
    #1;
    reset = 1'b0;
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    #1;
    do_reset();

    // Stage-0 ALU forward
    clear_inputs(); set_port(0, 8, 0, 1); set_stage(0, 8, 1, 1);
    checkOutput();
    check("alu_sel0", 64'(fwd_sel[0 +: SW]), 64'(1));
    check("alu_stall", 64'(stall), 64'(0));
    tick();

    // Load-use: not ready, then ready, then want-only
    clear_inputs(); set_port(1, 9, 0, 1); set_stage(1, 9, 1, 0);
    checkOutput();
    check("lu_stall", 64'(stall), 64'(1));
    check("lu_sel1", 64'(fwd_sel[SW +: SW]), 64'(0));
    tick();
    set_stage(1, 9, 1, 1);
    checkOutput();
    check("lu_ready_sel1", 64'(fwd_sel[SW +: SW]), 64'(2));
    tick();
    set_stage(1, 9, 1, 0); set_port(1, 9, 1, 0);
    checkOutput();
    check("lu_want_stall", 64'(stall), 64'(0));
    tick();

    // Long op to r12, stalled reader, completion bypass
    clear_inputs(); issue_valid = 1'b1; issue_dst = 12;
    checkOutput();
    check("long_accept", 64'(issue_accept), 64'(1));
    tick();
    clear_inputs(); set_port(0, 12, 0, 1);
    checkOutput();
    check("long_pend12", 64'(pending[12]), 64'(1));
    check("long_stall", 64'(stall), 64'(1));
    tick();
    checkOutput(); tick();
    cmpl_valid = 1'b1; cmpl_dst = 12;
    checkOutput();
    check("long_cmpl_sel0", 64'(fwd_sel[0 +: SW]), 64'(4));
    check("long_cmpl_stall", 64'(stall), 64'(0));
    tick();
    clear_inputs();
    checkOutput();
    check("long_cleared", 64'(pending[12]), 64'(0));
    tick();

    // WAW stall and same-cycle complete+reissue
    issue_valid = 1'b1; issue_dst = 12;
    checkOutput(); tick();
    checkOutput();
    check("waw_stall", 64'(stall), 64'(1));
    check("waw_accept", 64'(issue_accept), 64'(0));
    tick();
    cmpl_valid = 1'b1; cmpl_dst = 12;
    checkOutput();
    check("same_accept", 64'(issue_accept), 64'(1));
    tick();
    clear_inputs();
    checkOutput();
    check("same_pend12", 64'(pending[12]), 64'(1));
    tick();
    cmpl_valid = 1'b1; cmpl_dst = 12;
    checkOutput(); tick();

    // Spurious completion and issue to r0
    clear_inputs(); cmpl_valid = 1'b1; cmpl_dst = 5;
    checkOutput(); tick();
    clear_inputs();
    checkOutput();
    check("err_set", 64'(err_sticky), 64'(1));
    tick();
    issue_valid = 1'b1; issue_dst = 0;
    checkOutput(); tick();
    clear_inputs();
    checkOutput();
    check("r0_busy", 64'(busy), 64'(0));
    check("err_held", 64'(err_sticky), 64'(1));
    tick();

    // Reset while a register is pending
    issue_valid = 1'b1; issue_dst = 12;
    checkOutput(); tick();
    clear_inputs();
    checkOutput();
    do_reset();

    // Counter saturation
    clear_inputs(); ext_stall = 1'b1;
    repeat (20) begin checkOutput(); tick(); end
    ext_stall = 1'b0;
    checkOutput();
    check("sat_count", 64'(stall_count), 64'(SAT));
    tick();

    // Randomized traffic on a small register window
    do_reset();
    repeat (300) begin
      applyStimulus();
      checkOutput();
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
